// File: rtl/icache_responder.sv
// icache_responder
//   Direct-mapped instruction cache, one 32-bit word per line, 2^INDEX_BITS lines.
//   A lookup of IF_Addr in IDLE returns a registered hit flag and word one cycle
//   later. A miss raises a level fill request to the memory controller, writes
//   the returned word into the line and reports it as a hit on the next cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rdy          global enable; when low all state and outputs hold
//   IF_Addr      fetch address (fetcher npc), looked up on every enabled IDLE edge
//   IC_Clear     invalidate every line
//   IC_Instr_Hit registered: IC_Instr is valid for the address sampled last edge
//   IC_Instr     registered instruction word (holds while IC_Instr_Hit is low)
//   MC_Req       fill request, held until MC_Done
//   MC_Addr      word-aligned fill address
//   MC_Done      one-cycle fill completion pulse, MC_Data valid with it
//   MC_Data      fill word
//
// state  | meaning
// S_IDLE | look up IF_Addr every enabled edge
// S_MISS | fill request outstanding, waiting for MC_Done

module icache_responder #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] IF_Addr,
    input  logic        IC_Clear,
    output logic        IC_Instr_Hit,
    output logic [31:0] IC_Instr,
    output logic        MC_Req,
    output logic [31:0] MC_Addr,
    input  logic        MC_Done,
    input  logic [31:0] MC_Data
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MISS = 1'b1;

    logic [0:0]            state;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    // Byte offset is never stored; the miss address is kept word-granular.
    logic [31:2]           miss_word;
    logic                  clear_pending;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic                  lookup_hit;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  fill_ok;
    logic                  unused_addr_bits;

    assign lookup_idx = IF_Addr[INDEX_BITS+1:2];
    assign lookup_tag = IF_Addr[31:INDEX_BITS+2];
    // A clear on the lookup edge invalidates the line being read, so it is a miss.
    assign lookup_hit = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag) && !IC_Clear;

    assign fill_idx = miss_word[INDEX_BITS+1:2];
    // Any clear seen during this miss, including on the completing edge, voids the fill.
    assign fill_ok  = (state == S_MISS) && MC_Done && !IC_Clear && !clear_pending;

    assign MC_Addr = {miss_word, 2'b00};

    assign unused_addr_bits = ^IF_Addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            valid         <= '0;
            miss_word     <= '0;
            clear_pending <= 1'b0;
            IC_Instr_Hit  <= 1'b0;
            IC_Instr      <= '0;
            MC_Req        <= 1'b0;
        end else if (rdy) begin
            if (IC_Clear) begin
                valid <= '0;
            end
            if (state == S_IDLE) begin
                if (lookup_hit) begin
                    IC_Instr_Hit <= 1'b1;
                    IC_Instr     <= data_mem[lookup_idx];
                end else begin
                    IC_Instr_Hit  <= 1'b0;
                    miss_word     <= IF_Addr[31:2];
                    MC_Req        <= 1'b1;
                    clear_pending <= 1'b0;
                    state         <= S_MISS;
                end
            end else begin
                IC_Instr_Hit <= 1'b0;
                if (IC_Clear) begin
                    clear_pending <= 1'b1;
                end
                if (MC_Done) begin
                    MC_Req <= 1'b0;
                    state  <= S_IDLE;
                    if (fill_ok) begin
                        valid[fill_idx] <= 1'b1;
                        IC_Instr_Hit    <= 1'b1;
                        IC_Instr        <= MC_Data;
                    end
                end
            end
        end
    end

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rdy && fill_ok) begin
            tag_mem[fill_idx]  <= miss_word[31:INDEX_BITS+2];
            data_mem[fill_idx] <= MC_Data;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] IF_Addr;
    logic        IC_Clear;
    logic        IC_Instr_Hit;
    logic [31:0] IC_Instr;
    logic        MC_Req;
    logic [31:0] MC_Addr;
    logic        MC_Done;
    logic [31:0] MC_Data;

    icache_responder #(.INDEX_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .IF_Addr      (IF_Addr),
        .IC_Clear     (IC_Clear),
        .IC_Instr_Hit (IC_Instr_Hit),
        .IC_Instr     (IC_Instr),
        .MC_Req       (MC_Req),
        .MC_Addr      (MC_Addr),
        .MC_Done      (MC_Done),
        .MC_Data      (MC_Data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    // reference cache model
    bit          mvalid [256];
    logic [21:0] mtag   [256];
    logic [31:0] mdata  [256];
    bit          last_hit   = 1'b0;
    logic [31:0] last_instr = 32'h0;

    logic en_s = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_0113;
            32'h0000_0020: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic mclear();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    endtask

    // Monitor: every enabled edge that reports a hit consumes one scoreboard entry.
    always @(posedge clk) en_s <= rdy;

    always @(negedge clk) begin
        if (rst && en_s && IC_Instr_Hit) begin
            chk("hit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("instr", IC_Instr, exp_q.pop_front());
        end
    end

    task automatic lookup(input logic [31:0] a, input bit clr, output bit was_hit);
        int idx;
        idx = int'(a[9:2]);
        rdy = 1'b1;
        if (clr) begin
            IC_Clear = 1'b1;
            mclear();
        end
        was_hit = mvalid[idx] && (mtag[idx] == a[31:10]);
        IF_Addr = a;
        if (was_hit) exp_q.push_back(mdata[idx]);
        @(posedge clk); #1;
        IC_Clear = 1'b0;
        MC_Done  = 1'b0;
        if (was_hit) begin
            chk("lookup_hit", 32'(IC_Instr_Hit), 32'd1);
            chk("hit_no_req", 32'(MC_Req), 32'd0);
            last_hit   = 1'b1;
            last_instr = mdata[idx];
        end else begin
            chk("miss_req", 32'(MC_Req), 32'd1);
            chk("miss_addr", MC_Addr, {a[31:2], 2'b00});
            chk("miss_hit_low", 32'(IC_Instr_Hit), 32'd0);
            last_hit = 1'b0;
        end
        IF_Addr = $urandom();
    endtask

    // lat: edges from request to the MC_Done edge; clr_cyc: edge on which IC_Clear is raised (-1 none)
    task automatic complete_miss(input logic [31:0] a, input int lat, input int clr_cyc);
        bit          dropped;
        logic [31:0] al;
        int          idx;
        al      = {a[31:2], 2'b00};
        idx     = int'(a[9:2]);
        dropped = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k == clr_cyc) begin
                IC_Clear = 1'b1;
                mclear();
                dropped = 1'b1;
            end
            if (k == lat) begin
                MC_Done = 1'b1;
                MC_Data = memw(al);
                if (!dropped) exp_q.push_back(memw(al));
            end
            @(posedge clk); #1;
            IC_Clear = 1'b0;
            MC_Done  = 1'b0;
            MC_Data  = $urandom();
            if (k < lat) begin
                chk("req_held", 32'(MC_Req), 32'd1);
                chk("addr_stable", MC_Addr, al);
                chk("wait_hit_low", 32'(IC_Instr_Hit), 32'd0);
            end
        end
        chk("req_drop", 32'(MC_Req), 32'd0);
        chk("fill_hit", 32'(IC_Instr_Hit), 32'(!dropped));
        if (!dropped) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = a[31:10];
            mdata[idx]  = memw(al);
            last_hit    = 1'b1;
            last_instr  = memw(al);
        end else begin
            last_hit = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int lat, input int clr_cyc);
        bit h;
        lookup(a, clr_cyc == 0, h);
        if (!h) complete_miss(a, lat, clr_cyc);
    endtask

    task automatic stall(input int n);
        rdy     = 1'b0;
        IF_Addr = 32'h0000_0300;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("stall_hit", 32'(IC_Instr_Hit), 32'(last_hit));
            chk("stall_instr", IC_Instr, last_instr);
            chk("stall_req", 32'(MC_Req), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        mclear();
        rst      = 1'b0;
        rdy      = 1'b1;
        IF_Addr  = 32'h0;
        IC_Clear = 1'b0;
        MC_Done  = 1'b0;
        MC_Data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hit", 32'(IC_Instr_Hit), 32'd0);
        chk("rst_instr", IC_Instr, 32'd0);
        chk("rst_req", 32'(MC_Req), 32'd0);
        chk("rst_addr", MC_Addr, 32'd0);
        rst = 1'b1;

        // cold miss, re-hit, more fills, streaming hits (byte offset ignored)
        fetch(32'h0000_0000, 3, -1);
        fetch(32'h0000_0000, 3, -1);
        fetch(32'h0000_0004, 2, -1);
        fetch(32'h0000_0008, 1, -1);
        fetch(32'h0000_0000, 1, -1);
        fetch(32'h0000_0004, 1, -1);
        fetch(32'h0000_0008, 1, -1);
        fetch(32'h0000_0006, 1, -1);
        stall(3);

        // aliasing on index 4
        fetch(32'h0000_0010, 2, -1);
        fetch(32'h0000_0410, 2, -1);
        fetch(32'h0000_0010, 2, -1);
        fetch(32'h0000_0410, 4, -1);

        // clear during miss, clear on the completing edge, clear on an IDLE lookup
        fetch(32'h0000_0020, 3, 1);
        stall(2);
        fetch(32'h0000_0020, 2, -1);
        fetch(32'h0000_0024, 2, 2);
        fetch(32'h0000_0024, 1, -1);
        fetch(32'h0000_0000, 2, -1);
        fetch(32'h0000_0000, 2, 0);
        fetch(32'h0000_0000, 2, -1);

        // MC_Done while rdy low is lost
        lookup(32'h0000_0050, 1'b0, h);
        rdy     = 1'b0;
        MC_Done = 1'b1;
        MC_Data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        MC_Done = 1'b0;
        chk("rdylow_req", 32'(MC_Req), 32'd1);
        chk("rdylow_hit", 32'(IC_Instr_Hit), 32'd0);
        rdy = 1'b1;
        complete_miss(32'h0000_0050, 2, -1);

        // reset two cycles into a miss
        lookup(32'h0000_0040, 1'b0, h);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req", 32'(MC_Req), 32'd0);
        chk("midrst_hit", 32'(IC_Instr_Hit), 32'd0);
        chk("midrst_addr", MC_Addr, 32'd0);
        mclear();
        last_instr = 32'h0;
        @(posedge clk); #1;
        rst     = 1'b1;
        MC_Done = 1'b1;
        MC_Data = 32'hBAD0_BAD0;
        lookup(32'h0000_0000, 1'b0, h);
        complete_miss(32'h0000_0000, 3, -1);
        fetch(32'h0000_0000, 1, -1);

        stall(2);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
